mar_ram_unit: RTL and testbench

Memory stage of the 8-bit bus CPU: a 4-bit memory address register (MAR), an 8-bit memory data register (MDR) and a 16×8 RAM. It consumes the active-low memory control strobes produced by the control block (`\L_MA`, `\L_MD`, `\CE`, `\L_R`) and drives the shared bus on reads. It also contains a byte-stream loader FSM, so a program can be written into RAM before the CPU runs.

---
 rtl/mar_ram_unit.sv | 151 +++++++++++++++
 tb/tb_mar_ram_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mar_ram_unit.sv
// mar_ram_unit: memory stage of the 8-bit bus CPU.
// Holds the MAR, the MDR and a small RAM that reads combinationally onto the
// shared bus. A byte-stream loader can fill the RAM sequentially while
// prog_mode is high; the active-low CPU strobes are ignored during that time.
module mar_ram_unit #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             addr_load_n,
  input  logic             mem_load_n,
  input  logic             ram_en_n,
  input  logic             ram_load_n,
  input  logic             prog_mode,
  input  logic             prog_valid,
  input  logic [WIDTH-1:0] prog_data,
  output logic             prog_ready,
  output logic             prog_done,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_oe,
  output logic [AW-1:0]    mar_addr,
  output logic             err
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t           state, state_nxt;
  logic [AW-1:0]    mar;
  logic [WIDTH-1:0] mdr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    ptr;
  logic [WIDTH-1:0] byte_p1;
  logic             prog_mode_p1;
  logic             mode_rise;
  logic             illegal_strobe;
  logic             run_write;
  logic             ldr_write;
  logic             accept;

  // prog_mode is compared against its previous sample to find the 0->1 edge
  assign mode_rise      = prog_mode && !prog_mode_p1;
  // Driving the bus while writing it back is a bus conflict; the write is dropped
  assign illegal_strobe = !prog_mode && !ram_en_n && !ram_load_n;
  assign run_write      = !prog_mode && !ram_load_n && ram_en_n;
  // A latched loader byte is committed even if prog_mode has already fallen
  assign ldr_write      = (state == S_WRITE);

  assign bus_out  = mem[mar];
  // Gated by rst_n so the bus is released the moment reset is asserted
  assign bus_oe   = rst_n && !ram_en_n && !prog_mode;
  assign mar_addr = mar;

  // Loader next-state and handshake decode
  always_comb begin
    state_nxt  = state;
    prog_ready = 1'b0;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        prog_ready = rst_n && prog_mode && !prog_done;
        if (prog_valid && prog_ready) begin
          accept    = 1'b1;
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Loader state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Loader pointer, completion flag, mode edge detector and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prog_mode_p1 <= 1'b0;
      ptr          <= '0;
      prog_done    <= 1'b0;
      byte_p1      <= '0;
      err          <= 1'b0;
    end else begin
      prog_mode_p1 <= prog_mode;
      if (accept) begin
        byte_p1 <= prog_data;
      end
      if (mode_rise) begin
        ptr       <= '0;
        prog_done <= 1'b0;
      end else if (ldr_write) begin
        ptr <= (ptr == LAST_ADDR) ? '0 : ptr + AW'(1);
        if (ptr == LAST_ADDR) begin
          prog_done <= 1'b1;
        end
      end
      if (illegal_strobe) begin
        err <= 1'b1;
      end
    end
  end

  // MAR and MDR capture from the bus in run mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mar <= '0;
      mdr <= '0;
    end else if (!prog_mode) begin
      if (!addr_load_n) begin
        mar <= bus_in[AW-1:0];
      end
      if (!mem_load_n) begin
        mdr <= bus_in;
      end
    end
  end

  // RAM array: CPU write from pre-edge MAR/MDR, loader write from its pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (run_write) begin
        mem[mar] <= mdr;
      end
      if (ldr_write) begin
        mem[ptr] <= byte_p1;
      end
    end
  end

endmodule

// File: tb/tb_mar_ram_unit.sv
// Self-checking bench for mar_ram_unit: a RAM reference model predicts every
// bus read, a monitor checks them as the DUT drives the bus, and direct checks
// cover reset, the loader handshake and the sticky error flag.
module tb_mar_ram_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] bus_in;
  logic       addr_load_n, mem_load_n, ram_en_n, ram_load_n;
  logic       prog_mode, prog_valid;
  logic [7:0] prog_data;
  logic       prog_ready, prog_done;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic [3:0] mar_addr;
  logic       err;

  mar_ram_unit #(.DEPTH(16), .WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus_in(bus_in),
    .addr_load_n(addr_load_n), .mem_load_n(mem_load_n),
    .ram_en_n(ram_en_n), .ram_load_n(ram_load_n),
    .prog_mode(prog_mode), .prog_valid(prog_valid), .prog_data(prog_data),
    .prog_ready(prog_ready), .prog_done(prog_done),
    .bus_out(bus_out), .bus_oe(bus_oe), .mar_addr(mar_addr), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
  } rd_t;

  rd_t        exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  // Reference model of the architectural state
  logic [7:0] m_mem [16];
  logic [3:0] m_mar;
  logic [7:0] m_mdr;
  logic       m_err;
  logic [7:0] stream [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle the DUT drives the bus must match the next prediction
  always @(negedge clk) begin : monitor
    rd_t e;
    if (bus_oe === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_read: bus_out=%0h addr=%0h with no read pending", bus_out, mar_addr);
      end else begin
        e = exp_q.pop_front();
        check("read_data", {24'd0, bus_out}, {24'd0, e.d});
        check("read_addr", {28'd0, mar_addr}, {28'd0, e.a});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic strobes_idle();
    addr_load_n = 1'b1;
    mem_load_n  = 1'b1;
    ram_en_n    = 1'b1;
    ram_load_n  = 1'b1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    m_mar = 4'h0;
    m_mdr = 8'h00;
    m_err = 1'b0;
  endtask

  // One run-mode cycle: drive strobes, predict the read, apply edge semantics
  task automatic run_cycle(input logic ma, input logic md, input logic ce,
                           input logic lr, input logic [7:0] bus);
    addr_load_n = ma;
    mem_load_n  = md;
    ram_en_n    = ce;
    ram_load_n  = lr;
    bus_in      = bus;
    if (!ce) exp_q.push_back('{a: m_mar, d: m_mem[m_mar]});
    @(posedge clk);
    if (!ce && !lr) m_err = 1'b1;
    else if (!lr) m_mem[m_mar] = m_mdr;
    if (!ma) m_mar = bus[3:0];
    if (!md) m_mdr = bus;
    #1;
  endtask

  task automatic read_word(input logic [3:0] a);
    run_cycle(1'b0, 1'b1, 1'b1, 1'b1, {4'($urandom), a});
    run_cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'($urandom));
  endtask

  task automatic half_cycle();
    @(negedge clk);
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] target;
    logic       ma, md, ce, lr;

    rst_n      = 1'b0;
    prog_mode  = 1'b0;
    prog_valid = 1'b0;
    prog_data  = 8'h00;
    bus_in     = 8'h00;
    strobes_idle();
    model_reset();
    stream[0] = 8'h4E; stream[1] = 8'h2F; stream[2] = 8'h50; stream[3] = 8'h00;
    for (int i = 4; i < 16; i++) stream[i] = 8'($urandom);

    repeat (2) @(posedge clk);
    #1;
    check("reset_bus_out", {24'd0, bus_out}, 32'h0);
    check("reset_bus_oe", {31'd0, bus_oe}, 32'h0);
    check("reset_mar", {28'd0, mar_addr}, 32'h0);
    check("reset_err", {31'd0, err}, 32'h0);
    check("reset_prog_ready", {31'd0, prog_ready}, 32'h0);
    check("reset_prog_done", {31'd0, prog_done}, 32'h0);
    rst_n = 1'b1;
    next_edge();

    // Loader stream with CPU strobes (including the illegal pair) held active
    prog_mode   = 1'b1;
    prog_valid  = 1'b1;
    addr_load_n = 1'b0;
    mem_load_n  = 1'b0;
    ram_en_n    = 1'b0;
    ram_load_n  = 1'b0;
    for (int c = 0; c < 32; c++) begin
      prog_data = stream[c / 2];
      bus_in    = 8'($urandom);
      half_cycle();
      check("load_ready_toggle", {31'd0, prog_ready}, {31'd0, (c % 2) == 0});
      check("load_done_low", {31'd0, prog_done}, 32'h0);
      next_edge();
    end
    prog_data = 8'hFF;
    for (int c = 0; c < 4; c++) begin
      half_cycle();
      check("load_done_high", {31'd0, prog_done}, 32'h1);
      check("load_ready_after_done", {31'd0, prog_ready}, 32'h0);
      next_edge();
    end
    for (int i = 0; i < 16; i++) m_mem[i] = stream[i];
    strobes_idle();
    prog_mode  = 1'b0;
    prog_valid = 1'b0;
    check("prog_mode_mar_ignored", {28'd0, mar_addr}, 32'h0);
    check("prog_mode_err_ignored", {31'd0, err}, 32'h0);

    read_word(4'hE);
    for (int i = 0; i < 16; i++) read_word(4'(i));

    // STA sequence with a simultaneous MAR load on the write edge
    run_cycle(1'b0, 1'b1, 1'b1, 1'b1, 8'hDF);
    run_cycle(1'b1, 1'b0, 1'b1, 1'b1, 8'hA5);
    run_cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h03);
    run_cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'($urandom));
    read_word(4'hF);

    // Random legal strobe mixes
    for (int n = 0; n < 150; n++) begin
      ma = 1'($urandom);
      md = 1'($urandom);
      ce = 1'($urandom);
      lr = 1'($urandom);
      if (!ce && !lr) lr = 1'b1;
      run_cycle(ma, md, ce, lr, 8'($urandom));
    end
    for (int i = 0; i < 16; i++) read_word(4'(i));

    // Illegal strobe pair: write suppressed, sticky err
    check("err_before_illegal", {31'd0, err}, {31'd0, m_err});
    target = m_mar;
    run_cycle(1'b1, 1'b0, 1'b1, 1'b1, ~m_mem[m_mar]);
    run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'($urandom));
    check("err_set", {31'd0, err}, {31'd0, m_err});
    repeat (3) run_cycle(1'b1, 1'b1, 1'b1, 1'b1, 8'($urandom));
    check("err_sticky", {31'd0, err}, {31'd0, m_err});
    read_word(target);

    // Re-raise prog_mode after a full load: done clears, then drop mid-write
    strobes_idle();
    prog_mode  = 1'b1;
    prog_valid = 1'b1;
    prog_data  = 8'h77;
    half_cycle();
    check("rise_done_still_set", {31'd0, prog_done}, 32'h1);
    check("rise_ready_low", {31'd0, prog_ready}, 32'h0);
    next_edge();
    half_cycle();
    check("rise_done_cleared", {31'd0, prog_done}, 32'h0);
    check("rise_ready_high", {31'd0, prog_ready}, 32'h1);
    next_edge();
    prog_mode  = 1'b0;
    prog_valid = 1'b0;
    half_cycle();
    check("drop_in_write_ready", {31'd0, prog_ready}, 32'h0);
    next_edge();
    m_mem[0] = 8'h77;
    read_word(4'h0);

    // Re-raise again: pointer restarts at word 0, other words intact
    strobes_idle();
    prog_mode  = 1'b1;
    prog_valid = 1'b1;
    prog_data  = 8'h3C;
    half_cycle();
    check("rerise_ready", {31'd0, prog_ready}, 32'h1);
    next_edge();
    prog_valid = 1'b0;
    half_cycle();
    check("rerise_write_ready", {31'd0, prog_ready}, 32'h0);
    check("rerise_done", {31'd0, prog_done}, 32'h0);
    next_edge();
    prog_mode = 1'b0;
    m_mem[0] = 8'h3C;
    read_word(4'h0);
    read_word(4'h1);

    // Asynchronous reset in the middle of a loader write
    strobes_idle();
    prog_mode  = 1'b1;
    prog_valid = 1'b1;
    prog_data  = 8'h99;
    half_cycle();
    check("pre_reset_ready", {31'd0, prog_ready}, 32'h1);
    @(posedge clk);
    #3;
    prog_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_reset_bus_out", {24'd0, bus_out}, 32'h0);
    check("async_reset_bus_oe", {31'd0, bus_oe}, 32'h0);
    check("async_reset_mar", {28'd0, mar_addr}, 32'h0);
    check("async_reset_err", {31'd0, err}, 32'h0);
    check("async_reset_ready", {31'd0, prog_ready}, 32'h0);
    check("async_reset_done", {31'd0, prog_done}, 32'h0);
    next_edge();
    prog_mode = 1'b0;
    rst_n = 1'b1;
    next_edge();
    read_word(4'h0);
    read_word(4'h5);
    read_word(4'hF);
    strobes_idle();
    repeat (2) next_edge();
    check("reads_all_observed", exp_q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
